// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM encoding,
// queued command layout and opcode latency lookup.
package alu_seq_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_MOD   = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_CLEAR = 4'b1111;

  localparam int CMD_W = 37;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } seq_state_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic        chain;
  } cmd_t;

  function automatic int unsigned op_latency(input logic [3:0] op,
                                             input int unsigned mul_cycles,
                                             input int unsigned div_cycles);
    case (op)
      OP_MUL:         return mul_cycles;
      OP_DIV, OP_MOD: return div_cycles;
      default:        return 1;
    endcase
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue for the sequencer: power-of-two depth, synchronous reset,
// head word visible combinationally on rdata.
module alu_cmd_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, drives them to an external combinational ALU for a
// per-opcode settle time, and holds each result until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a queued command; pops and loads ALU inputs
// EXEC  | ALU inputs held, settle counter running down to zero
// DONE  | result captured and presented until rsp_ready
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_chain,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic        alu_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_error,
  output logic [15:0] prev_result,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int unsigned MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  seq_state_t       state, state_nxt;
  cmd_t             head, wr_cmd;
  logic             fifo_full, fifo_empty;
  logic             push, pop, load, capture;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      cap_result;
  logic             cap_error;

  assign wr_cmd    = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, chain: cmd_chain};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_cmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!fifo_empty)   state_nxt = ST_EXEC;
      ST_EXEC: if (cnt == '0)     state_nxt = ST_DONE;
      ST_DONE: if (rsp_ready)     state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load      = (state == ST_IDLE) && !fifo_empty;
    pop       = load;
    capture   = (state == ST_EXEC) && (cnt == '0);
    rsp_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE) || !fifo_empty;
  end

  // NOP and CLEAR never look at the ALU outputs.
  always_comb begin
    cap_result = alu_result;
    cap_error  = alu_error;
    if (alu_opcode == OP_NOP) begin
      cap_result = prev_result;
      cap_error  = 1'b0;
    end else if (alu_opcode == OP_CLEAR) begin
      cap_result = '0;
      cap_error  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_opcode  <= OP_NOP;
      alu_a       <= '0;
      alu_b       <= '0;
      cnt         <= '0;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      prev_result <= '0;
      err_count   <= '0;
    end else begin
      if (load) begin
        alu_opcode <= head.opcode;
        alu_a      <= head.chain ? prev_result : head.a;
        alu_b      <= head.b;
        cnt        <= CNT_W'(op_latency(head.opcode, MUL_CYCLES, DIV_CYCLES) - 1);
      end else if (state == ST_EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        rsp_result  <= cap_result;
        rsp_error   <= cap_error;
        prev_result <= cap_result;
        if (cap_error && err_count != 8'hFF) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU on the datapath
// side and a sequential result model built from plain arithmetic.
module tb_alu_op_sequencer;

  localparam int MUL_C = 4;
  localparam int DIV_C = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        cmd_chain = 1'b0;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_result;
  logic        alu_error;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_error;
  logic [15:0] prev_result;
  logic [7:0]  err_count;
  logic        busy;

  int checks = 0;
  int passes = 0;

  logic [15:0] mdl_prev;
  int          mdl_err;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        chain;
  } tcmd_t;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .FIFO_DEPTH (4),
    .MUL_CYCLES (MUL_C),
    .DIV_CYCLES (DIV_C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_chain   (cmd_chain),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_error   (alu_error),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_error   (rsp_error),
    .prev_result (prev_result),
    .err_count   (err_count),
    .busy        (busy)
  );

  // Bench ALU: {error, result}. Unused opcodes return a loud error pattern.
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    logic [15:0] r;
    case (op)
      4'd1:  r = a + b;
      4'd2:  r = a - b;
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  begin p = a * b; r = p[15:0]; end
      4'd6:  r = a ^ b;
      4'd7:  r = a << b[3:0];
      4'd8:  begin if (b == 0) return {1'b1, 16'h0000}; r = a % b; end
      4'd9:  r = a >> b[3:0];
      4'd13: begin if (b == 0) return {1'b1, 16'h0000}; r = a / b; end
      4'd14: return {1'b1, 16'hDEAD};
      default: return {1'b1, 16'h5A5A};
    endcase
    return {1'b0, r};
  endfunction

  logic [16:0] alu_out;
  always_comb alu_out = alu_fn(alu_opcode, alu_a, alu_b);
  assign alu_result = alu_out[15:0];
  assign alu_error  = alu_out[16];

  function automatic int exp_lat(input logic [3:0] op);
    if (op == 4'd5) return MUL_C;
    if (op == 4'd8 || op == 4'd13) return DIV_C;
    return 1;
  endfunction

  task automatic model_step(input tcmd_t c, output logic [15:0] r, output logic e);
    logic [16:0] o;
    if (c.op == 4'd0) begin
      r = mdl_prev; e = 1'b0;
    end else if (c.op == 4'd15) begin
      r = 16'h0; e = 1'b0;
    end else begin
      o = alu_fn(c.op, c.chain ? mdl_prev : c.a, c.b);
      r = o[15:0]; e = o[16];
    end
    mdl_prev = r;
    if (e && mdl_err < 255) mdl_err++;
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mdl_prev = 16'h0;
    mdl_err  = 0;
    @(negedge clk);
  endtask

  // Pushes one command, waits for its response, returns it and acknowledges.
  task automatic do_op(input tcmd_t c, output logic [15:0] r, output logic e, output int edges);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = c.op; cmd_a = c.a; cmd_b = c.b; cmd_chain = c.chain;
    w = 0;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    edges = 0;
    while (!rsp_valid && edges < 100) begin @(negedge clk); edges++; end
    r = rsp_result;
    e = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passes++;
    checks++; if (rsp_result !== 16'h0 || rsp_error !== 1'b0) $display("FAIL reset_rsp got %h/%b want 0/0", rsp_result, rsp_error); else passes++;
    checks++; if (prev_result !== 16'h0 || err_count !== 8'h0) $display("FAIL reset_prev_err got %h/%h want 0/0", prev_result, err_count); else passes++;
    checks++; if (alu_opcode !== 4'h0 || alu_a !== 16'h0 || alu_b !== 16'h0) $display("FAIL reset_alu got %h/%h/%h want 0/0/0", alu_opcode, alu_a, alu_b); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_add();
    tcmd_t c; logic [15:0] r, er; logic e, ee; int ed;
    c = '{op: 4'd1, a: 16'd3, b: 16'd4, chain: 1'b0};
    model_step(c, er, ee);
    do_op(c, r, e, ed);
    checks++; if (ed !== 2) $display("FAIL add_latency got %0d want 2", ed); else passes++;
    checks++; if (r !== er || r !== 16'd7 || e !== 1'b0) $display("FAIL add_result got %0d/%b want 7/0", r, e); else passes++;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL add_retire got %b/%b want 0/0", rsp_valid, busy); else passes++;
  endtask

  task automatic test_div();
    tcmd_t c; logic [15:0] r, er; logic e, ee; int ed;
    c = '{op: 4'd13, a: 16'd40000, b: 16'd5, chain: 1'b0};
    model_step(c, er, ee);
    do_op(c, r, e, ed);
    checks++; if (ed !== DIV_C + 1) $display("FAIL div_latency got %0d want %0d", ed, DIV_C + 1); else passes++;
    checks++; if (r !== 16'd8000 || e !== 1'b0) $display("FAIL div_result got %0d/%b want 8000/0", r, e); else passes++;
    c = '{op: 4'd13, a: 16'd123, b: 16'd0, chain: 1'b0};
    model_step(c, er, ee);
    do_op(c, r, e, ed);
    checks++; if (e !== 1'b1 || r !== er) $display("FAIL div0_error got %h/%b want %h/1", r, e, er); else passes++;
    checks++; if (err_count !== 8'd1) $display("FAIL div0_err_count got %0d want 1", err_count); else passes++;
  endtask

  task automatic test_chain();
    tcmd_t c; logic [15:0] r, er; logic e, ee; int ed;
    c = '{op: 4'd5, a: 16'd200, b: 16'd5, chain: 1'b0};
    model_step(c, er, ee);
    do_op(c, r, e, ed);
    checks++; if (ed !== MUL_C + 1) $display("FAIL mul_latency got %0d want %0d", ed, MUL_C + 1); else passes++;
    checks++; if (r !== 16'd1000 || e !== 1'b0) $display("FAIL mul_result got %0d/%b want 1000/0", r, e); else passes++;
    c = '{op: 4'd7, a: 16'hBEEF, b: 16'd2, chain: 1'b1};
    model_step(c, er, ee);
    do_op(c, r, e, ed);
    checks++; if (r !== 16'd4000 || e !== 1'b0) $display("FAIL chain_result got %0d/%b want 4000/0", r, e); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (prev_result !== 16'd4000) $display("FAIL chain_prev got %0d want 4000", prev_result); else passes++;
    checks++; if (alu_opcode !== 4'd7 || alu_a !== 16'd1000 || alu_b !== 16'd2) $display("FAIL alu_hold got %h/%0d/%0d want 7/1000/2", alu_opcode, alu_a, alu_b); else passes++;
  endtask

  task automatic test_clear();
    tcmd_t c; logic [15:0] r, er; logic e, ee; int ed;
    c = '{op: 4'd1, a: 16'd3, b: 16'd4, chain: 1'b0};
    model_step(c, er, ee); do_op(c, r, e, ed);
    c = '{op: 4'd15, a: 16'h1234, b: 16'h5678, chain: 1'b0};
    model_step(c, er, ee); do_op(c, r, e, ed);
    checks++; if (r !== 16'h0 || e !== 1'b0 || prev_result !== 16'h0) $display("FAIL clear got %h/%b prev %h want 0/0 prev 0", r, e, prev_result); else passes++;
    c = '{op: 4'd0, a: 16'h1111, b: 16'h2222, chain: 1'b0};
    model_step(c, er, ee); do_op(c, r, e, ed);
    checks++; if (r !== 16'h0 || e !== 1'b0 || ed !== 2) $display("FAIL nop got %h/%b lat %0d want 0/0 lat 2", r, e, ed); else passes++;
  endtask

  task automatic test_random();
    logic [3:0] ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd13, 4'd14, 4'd15};
    tcmd_t c; logic [15:0] r, er; logic e, ee; int ed;
    for (int i = 0; i < 30; i++) begin
      c.op    = ops[$urandom_range(0, 12)];
      c.a     = 16'($urandom);
      c.b     = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      c.chain = 1'($urandom_range(0, 1));
      model_step(c, er, ee);
      do_op(c, r, e, ed);
      checks++;
      if (r !== er || e !== ee || ed !== exp_lat(c.op) + 1)
        $display("FAIL random_op%0d op %h got %h/%b lat %0d want %h/%b lat %0d", i, c.op, r, e, ed, er, ee, exp_lat(c.op) + 1);
      else passes++;
    end
    checks++; if (prev_result !== mdl_prev || err_count !== 8'(mdl_err)) $display("FAIL random_state got %h/%0d want %h/%0d", prev_result, err_count, mdl_prev, mdl_err); else passes++;
  endtask

  task automatic test_back_to_back();
    tcmd_t q[$];
    tcmd_t c;
    logic [3:0] ops [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd9};
    logic [15:0] er; logic ee;
    int acc, w;
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      c.op = ops[$urandom_range(0, 6)];
      c.a = 16'($urandom); c.b = 16'($urandom); c.chain = 1'($urandom_range(0, 1));
      cmd_valid = 1'b1; cmd_opcode = c.op; cmd_a = c.a; cmd_b = c.b; cmd_chain = c.chain;
      if (cmd_ready) begin acc++; q.push_back(c); end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (acc !== 5) $display("FAIL b2b_accepted got %0d want 5", acc); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_full got ready %b busy %b want 0/1", cmd_ready, busy); else passes++;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (!rsp_valid && w < 100) begin @(negedge clk); w++; end
      if (q.size() > 0) c = q.pop_front();
      model_step(c, er, ee);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_error !== ee)
        $display("FAIL b2b_result%0d got %b %h/%b want 1 %h/%b", k, rsp_valid, rsp_result, rsp_error, er, ee);
      else passes++;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL b2b_drain got busy %b ready %b want 0/1", busy, cmd_ready); else passes++;
  endtask

  task automatic test_reset_mid_exec();
    tcmd_t c; logic [15:0] r, er; logic e, ee; int ed, seen;
    c = '{op: 4'd14, a: 16'd10, b: 16'd20, chain: 1'b0};
    model_step(c, er, ee); do_op(c, r, e, ed);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = 4'd13; cmd_a = 16'd100; cmd_b = 16'd7; cmd_chain = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || alu_opcode !== 4'd13) $display("FAIL rst_pre got busy %b op %h want 1/d", busy, alu_opcode); else passes++;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    mdl_prev = 16'h0; mdl_err = 0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || prev_result !== 16'h0 || err_count !== 8'h0 ||
        rsp_result !== 16'h0 || rsp_error !== 1'b0 || alu_opcode !== 4'h0 || alu_a !== 16'h0 || alu_b !== 16'h0)
      $display("FAIL rst_mid_exec got v%b b%b r%b p%h e%h res%h err%b op%h a%h b%h want all idle", rsp_valid, busy, cmd_ready,
               prev_result, err_count, rsp_result, rsp_error, alu_opcode, alu_a, alu_b);
    else passes++;
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (rsp_valid) seen++; end
    checks++; if (seen !== 0) $display("FAIL rst_no_rsp got %0d valid cycles want 0", seen); else passes++;
  endtask

  task automatic test_err_saturation();
    tcmd_t c; logic [15:0] r, er; logic e, ee; int ed;
    apply_reset();
    c = '{op: 4'd14, a: 16'd1, b: 16'd1, chain: 1'b0};
    for (int i = 0; i < 258; i++) begin
      model_step(c, er, ee);
      do_op(c, r, e, ed);
      if (i == 253) begin
        checks++; if (err_count !== 8'd254) $display("FAIL err_count_254 got %0d want 254", err_count); else passes++;
      end
    end
    checks++; if (err_count !== 8'd255) $display("FAIL err_count_sat got %0d want 255", err_count); else passes++;
  endtask

  initial begin
    mdl_prev = 16'h0;
    mdl_err  = 0;
    test_reset();
    test_add();
    test_div();
    test_chain();
    test_clear();
    test_random();
    test_back_to_back();
    test_reset_mid_exec();
    test_err_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue depth (power of two, >=2).
REQ-002 Parameter MUL_CYCLES, default 4, ALU settle cycles for MULTIPLY (0101).
REQ-003 Parameter DIV_CYCLES, default 8, ALU settle cycles for DIVIDE (1101) and MOD (1000).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  queue can accept a command.
REQ-008 cmd_opcode  input  4  ALU opcode (0000 NOP … 1111 CLEAR).
REQ-009 cmd_a, cmd_b  input  16 each  operands.
REQ-010 cmd_chain  input  1  use previous result as operand A.
REQ-011 alu_opcode  output  4  registered opcode to ALU datapath.
REQ-012 alu_a, alu_b  output  16 each  registered operands to ALU.
REQ-013 alu_result  input  16  combinational ALU result.
REQ-014 alu_error  input  1  combinational ALU error flag.
REQ-015 rsp_valid  output  1  result available.
REQ-016 rsp_ready  input  1  consumer accepts result.
REQ-017 rsp_result  output  16  captured result.
REQ-018 rsp_error  output  1  captured error.
REQ-019 prev_result  output  16  last completed result (chain source).
REQ-020 err_count  output  8  saturating count of errored results.
REQ-021 busy  output  1  FSM not IDLE or queue non-empty.

Function
REQ-022 Command push when cmd_valid && cmd_ready; cmd_ready = !full, based on registered full only (no push into a full queue even on a same-cycle pop).
REQ-023 FSM states IDLE, EXEC, DONE; encoding 2 bits.
REQ-024 IDLE: queue non-empty -> pop head, load alu_opcode/alu_a/alu_b (alu_a = prev_result when chain=1), load cnt = latency-1, go EXEC.
REQ-025 Latency: MUL_CYCLES for 0101, DIV_CYCLES for 1000/1101, 1 for all other opcodes.
REQ-026 EXEC: cnt != 0 -> decrement; cnt == 0 -> capture rsp_result/rsp_error from alu_result/alu_error, update prev_result, go DONE.
REQ-027 Opcode 0000: captured result = prev_result, error 0, ALU inputs ignored.
REQ-028 Opcode 1111: captured result = 0, error 0, prev_result cleared to 0.
REQ-029 DONE: rsp_valid=1, outputs stable; rsp_ready -> IDLE (next pop earliest following cycle).
REQ-030 Single-cycle op: push at edge N -> rsp_valid high after edge N+2; MUL after N+1+MUL_CYCLES; DIV/MOD after N+1+DIV_CYCLES.
REQ-031 err_count increments on each capture with error=1; saturates at 255.
REQ-032 alu_* outputs hold their value outside EXEC (no spurious toggling).
REQ-033 Queue ordering strictly FIFO; chain reads prev_result at pop time (after prior op completed).

Reset
REQ-034 reset: state IDLE, queue emptied, cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_error=0, prev_result=0, err_count=0, alu_opcode=0000, alu_a=alu_b=0, busy=0.
REQ-035 reset mid-EXEC or in DONE aborts the operation; no result captured.

Structure
REQ-036 Shared package alu_seq_pkg holds opcode constants, FSM state encoding, and the opcode-to-latency function.
REQ-037 Sub-module alu_cmd_fifo (37-bit wide, FIFO_DEPTH deep, sync reset) holds the command queue.

Verification
REQ-038 ADD a=3,b=4 pushed at edge 0 -> rsp_valid after edge 2, result 7, error 0.
REQ-039 DIV a=40000,b=5 -> rsp_valid after DIV_CYCLES+1 edges, result 8000, error 0; then DIV b=0 -> error 1, err_count 1.
REQ-040 MUL 200*5 then SHL chain=1,b=2 -> results 1000 then 4000; prev_result 4000.
REQ-041 rsp_ready=0, push 6 commands back-to-back -> 5 accepted (1 in FSM, 4 queued), cmd_ready low from then on; release rsp_ready -> results in order.
REQ-042 Assert reset during DIV EXEC cycle 3 -> next cycle all REQ-034 values, no rsp_valid pulse.
REQ-043 CLEAR (1111) after ADD 3+4 -> result 0, prev_result 0; NOP next -> result 0.
